button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/btn_pkg.sv | 23 ++
 rtl/evt_buf.sv | 44 ++++
 rtl/button_event.sv | 123 ++++++++++++
 tb/tb_button_event.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the button event classifier: FSM state encoding and event codes.
// GAP only exists when BUTTON_EVENT_DOUBLE_CLICK_EN is defined.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HELD     = 2'd1,
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      ST_GAP      = 2'd2,
`endif
      ST_WAIT_REL = 2'd3
   } state_t;

   localparam logic [2:0] EVT_NONE   = 3'd0;
   localparam logic [2:0] EVT_SHORT  = 3'd1;
   localparam logic [2:0] EVT_LONG   = 3'd2;
   localparam logic [2:0] EVT_DOUBLE = 3'd3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/evt_buf.sv
// One-entry event buffer with valid/ready hand-off and a sticky overflow flag.
// A new event is accepted when the buffer is empty or draining on the same edge.
module evt_buf
   import btn_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       emit,
   input  logic [2:0] emit_code,
   input  logic       ready,
   input  logic       ovf_clr,
   output logic       valid,
   output logic [2:0] code,
   output logic       ovf
);

   logic take;
   logic drop;

   assign take = valid & ready;
   assign drop = emit & valid & ~ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         code  <= EVT_NONE;
         ovf   <= 1'b0;
      end else begin
         if (emit && !drop) begin
            valid <= 1'b1;
            code  <= emit_code;
         end else if (take) begin
            valid <= 1'b0;
            code  <= EVT_NONE;
         end
         // a drop on the same edge as a clear keeps the flag set
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/button_event.sv
// Classifies debounced button activity into SHORT / LONG / DOUBLE events.
// Double-click detection (GAP state) is built only with BUTTON_EVENT_DOUBLE_CLICK_EN.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | button released, waiting for a press
// ST_HELD     | button down, timing towards LONG
// ST_GAP      | released after a short press, waiting for a second press
// ST_WAIT_REL | event already classified, waiting for release
module button_event
   import btn_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 12_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_db,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   input  logic       evt_ready,
   output logic       evt_ovf,
   input  logic       ovf_clr
);

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam int CNT_MAX = max_int(LONG_CYCLES, GAP_CYCLES);
`else
   localparam int CNT_MAX = LONG_CYCLES;
`endif
   localparam int               CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             btn_q;
   logic             rise, fall;
   logic             emit;
   logic [2:0]       emit_code;

   assign rise    = btn_db & ~btn_q;
   assign fall    = ~btn_db & btn_q;
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         btn_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         btn_q <= btn_db;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      emit      = 1'b0;
      emit_code = EVT_NONE;
      case (state)
         ST_IDLE: begin
            if (rise)
               state_nxt = ST_HELD;
         end
         ST_HELD: begin
            cnt_nxt = cnt_inc;
            if (btn_db && (cnt == LONG_TC)) begin
               emit      = 1'b1;
               emit_code = EVT_LONG;
               state_nxt = ST_WAIT_REL;
            end else if (fall) begin
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
               state_nxt = ST_GAP;
`else
               emit      = 1'b1;
               emit_code = EVT_SHORT;
               state_nxt = ST_IDLE;
`endif
            end
         end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
         ST_GAP: begin
            cnt_nxt = cnt_inc;
            // a second press on the timeout cycle still counts as a double click
            if (rise) begin
               emit      = 1'b1;
               emit_code = EVT_DOUBLE;
               state_nxt = ST_WAIT_REL;
            end else if (cnt == GAP_TC) begin
               emit      = 1'b1;
               emit_code = EVT_SHORT;
               state_nxt = ST_IDLE;
            end
         end
`endif
         ST_WAIT_REL: begin
            if (fall)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (state_nxt != state)
         cnt_nxt = '0;
   end

   evt_buf u_evt_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .emit      (emit),
      .emit_code (emit_code),
      .ready     (evt_ready),
      .ovf_clr   (ovf_clr),
      .valid     (evt_valid),
      .code      (evt_code),
      .ovf       (evt_ovf)
   );

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event (LONG_CYCLES=8, GAP_CYCLES=4); expected event loads
// are queued with their load cycle and matched by a monitor on the falling clock edge.
module tb_button_event;
   import btn_pkg::*;

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam bit DC = 1'b1;
`else
   localparam bit DC = 1'b0;
`endif
   // cycles from driving a 3-cycle press to the SHORT load
   localparam int SHORT_LAT = DC ? 8 : 4;

   typedef struct {
      logic [2:0] code;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_db;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic       evt_ready;
   logic       evt_ovf;
   logic       ovf_clr;

   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic prev_valid = 1'b0;
   logic prev_took = 1'b0;
   int   k;

   button_event #(.LONG_CYCLES(8), .GAP_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_db    (btn_db),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ready (evt_ready),
      .evt_ovf   (evt_ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic hold(input logic v, input int n);
      btn_db = v;
      repeat (n) step();
   endtask

   // a new load is a valid buffer that was empty or handed off on the previous edge
   always @(negedge clk) begin
      if (rst_n === 1'b1 && evt_valid === 1'b1 && (!prev_valid || prev_took)) begin
         check("evt_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("evt_code", evt_code, mon_e.code);
            check("evt_cycle", cyc, mon_e.cyc);
         end
      end
      prev_valid <= evt_valid;
      prev_took  <= evt_valid & evt_ready;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      btn_db    = 1'b0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;
      rst_n     = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("rst_valid", evt_valid, 0);
      check("rst_code", evt_code, EVT_NONE);
      check("rst_ovf", evt_ovf, 0);
      step();
      rst_n = 1'b1;
      hold(0, 3);

      // single short press
      sb.push_back('{EVT_SHORT, cyc + SHORT_LAT});
      hold(1, 3);
      hold(0, 10);

      // long press, nothing on release
      sb.push_back('{EVT_LONG, cyc + 9});
      hold(1, 20);
      hold(0, 10);

      // double-press pattern
      k = cyc;
      if (DC) begin
         sb.push_back('{EVT_DOUBLE, k + 6});
      end else begin
         sb.push_back('{EVT_SHORT, k + 4});
         sb.push_back('{EVT_SHORT, k + 9});
      end
      hold(1, 3);
      hold(0, 2);
      hold(1, 3);
      hold(0, 10);

      // overflow: consumer stalled, second SHORT is dropped
      evt_ready = 1'b0;
      sb.push_back('{EVT_SHORT, cyc + SHORT_LAT});
      hold(1, 3);
      hold(0, 10);
      hold(1, 3);
      hold(0, 10);
      @(negedge clk);
      check("ovf_hold_valid", evt_valid, 1);
      check("ovf_hold_code", evt_code, EVT_SHORT);
      check("ovf_set", evt_ovf, 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", evt_ovf, 0);

      // drop and clear on the same edge: set wins
      k = cyc;
      ovf_clr = 1'b1;
      hold(1, 3);
      btn_db = 1'b0;
      repeat (k + SHORT_LAT - cyc) step();
      @(negedge clk);
      check("ovf_set_wins", evt_ovf, 1);
      check("ovf_code_kept", evt_code, EVT_SHORT);
      step();
      @(negedge clk);
      check("ovf_clr_after", evt_ovf, 0);
      ovf_clr = 1'b0;
      hold(0, 5);

      // LONG emitted on the same edge the held SHORT is taken
      k = cyc;
      sb.push_back('{EVT_LONG, k + 9});
      btn_db = 1'b1;
      repeat (8) step();
      evt_ready = 1'b1;
      step();
      @(negedge clk);
      check("xfer_emit_valid", evt_valid, 1);
      check("xfer_emit_ovf", evt_ovf, 0);
      hold(1, 3);
      hold(0, 5);

      // reset in the middle of a press with a full buffer and overflow set
      evt_ready = 1'b0;
      sb.push_back('{EVT_SHORT, cyc + SHORT_LAT});
      hold(1, 3);
      hold(0, 10);
      hold(1, 3);
      hold(0, 10);
      btn_db = 1'b1;
      repeat (6) step();
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", evt_valid, 0);
      check("midrst_code", evt_code, EVT_NONE);
      check("midrst_ovf", evt_ovf, 0);
      btn_db = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      evt_ready = 1'b1;
      hold(0, 20);
      @(negedge clk);
      check("midrst_no_long", evt_valid, 0);

      // button already down when reset releases counts as a press
      rst_n = 1'b0;
      step();
      btn_db = 1'b1;
      step();
      rst_n = 1'b1;
      sb.push_back('{EVT_LONG, cyc + 9});
      hold(1, 12);
      hold(0, 5);

      repeat (3) step();
      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
